hc_csr_bank: RTL and testbench

Parametrised HardCloud MMIO register bank and accelerator control FSM, replacing the fixed two-buffer decode functions. It decodes CCI-P MMIO writes for the DSM base, the control register and NUM_BUFFERS address/size descriptor pairs. It answers MMIO reads with a registered 1-cycle response and drives accelerator reset/start from a control state machine. It also tracks run status and cycle count. It sits between the CCI-P c0 Rx/c2 Tx MMIO path and the accelerator datapath.

---
 rtl/hc_csr_bank_if.sv | 25 ++
 rtl/hc_csr_bank.sv | 186 ++++++++++++++++++
 tb/tb_hc_csr_bank.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/hc_csr_bank_if.sv
// HardCloud CCI-P MMIO channel: c0 Rx write/read strobes in, c2 Tx read response out.
// Latency: none (wires only); the bank registers the response one cycle after the read.
// Backpressure: none; every strobe is accepted and every read is answered.
// Ports: mmio_wr_valid/mmio_rd_valid/mmio_addr/mmio_tid/mmio_wdata (host -> bank),
//        mmio_rsp_valid/mmio_rsp_tid/mmio_rsp_data (bank -> host).
interface hc_csr_bank_if;
    logic        mmio_wr_valid;
    logic        mmio_rd_valid;
    logic [15:0] mmio_addr;      // dword address (byte address >> 2)
    logic [8:0]  mmio_tid;
    logic [63:0] mmio_wdata;
    logic        mmio_rsp_valid;
    logic [8:0]  mmio_rsp_tid;
    logic [63:0] mmio_rsp_data;

    modport master (
        output mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wdata,
        input  mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data
    );

    modport slave (
        input  mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wdata,
        output mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data
    );
endinterface

// File: rtl/hc_csr_bank.sv
// HardCloud MMIO register bank (DSM base, NUM_BUFFERS descriptors) plus accelerator control FSM.
// Latency: writes and control commands take effect next cycle; read response registered, 1 cycle.
// Backpressure: none; back-to-back reads each answered, simultaneous rd/wr reads pre-write value.
// Ports: clk, reset (sync, active high), bus (MMIO slave), accel_done (done pulse in),
//        dsm_base, buf_addr/buf_size (packed descriptors), accel_reset, accel_start, ctrl_state.
module hc_csr_bank #(
    parameter int          NUM_BUFFERS = 2,
    parameter logic [15:0] BUF_BASE    = 16'h120,
    parameter logic [15:0] DSM_ADDR    = 16'h110,
    parameter logic [15:0] CTRL_ADDR   = 16'h118,
    parameter logic [15:0] STATUS_ADDR = 16'h100
) (
    input  logic                      clk,
    input  logic                      reset,
    hc_csr_bank_if.slave              bus,
    input  logic                      accel_done,
    output logic [63:0]               dsm_base,
    output logic [64*NUM_BUFFERS-1:0] buf_addr,
    output logic [32*NUM_BUFFERS-1:0] buf_size,
    output logic                      accel_reset,
    output logic                      accel_start,
    output logic [2:0]                ctrl_state
);

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_IDLE = 3'd1,
        S_RUN  = 3'd2,
        S_STOP = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [31:0] CMD_ASSERT_RST   = 32'd0;
    localparam logic [31:0] CMD_DEASSERT_RST = 32'd1;
    localparam logic [31:0] CMD_START        = 32'd3;
    localparam logic [31:0] CMD_STOP         = 32'd7;

    localparam logic [15:0] DSM_DW     = DSM_ADDR >> 2;
    localparam logic [15:0] CTRL_DW    = CTRL_ADDR >> 2;
    localparam logic [15:0] STATUS0_DW = STATUS_ADDR >> 2;
    localparam logic [15:0] STATUS8_DW = (STATUS_ADDR >> 2) + 16'd2;
    localparam logic [15:0] BUF_DW     = BUF_BASE >> 2;

    state_t      state;
    logic        done_flag;
    logic [31:0] counter;
    logic [63:0] dsm_q;
    logic [63:0] addr_q [NUM_BUFFERS];
    logic [31:0] size_q [NUM_BUFFERS];

    logic        rsp_valid_q;
    logic [8:0]  rsp_tid_q;
    logic [63:0] rsp_data_q;
    logic [63:0] rd_mux;

    logic        ctrl_wr;
    logic        cfg_wr;
    logic [31:0] cmd;

    assign ctrl_wr = bus.mmio_wr_valid && (bus.mmio_addr == CTRL_DW);
    assign cmd     = bus.mmio_wdata[31:0];
    // Buffer/DSM configuration is frozen while the accelerator is running.
    assign cfg_wr  = bus.mmio_wr_valid && (state != S_RUN);

    // Configuration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            dsm_q <= '0;
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                addr_q[i] <= '0;
                size_q[i] <= '0;
            end
        end else if (cfg_wr) begin
            if (bus.mmio_addr == DSM_DW) begin
                dsm_q <= bus.mmio_wdata;
            end
            // Only the addr (+0) and size (+2) dwords of implemented descriptors decode;
            // the rest of the window falls through and is dropped.
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                if (bus.mmio_addr == BUF_DW + 16'(4 * i)) begin
                    addr_q[i] <= bus.mmio_wdata;
                end
                if (bus.mmio_addr == BUF_DW + 16'(4 * i + 2)) begin
                    size_q[i] <= bus.mmio_wdata[31:0];
                end
            end
        end
    end

    // Control FSM, run counter and done flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_RST;
            accel_reset <= 1'b1;
            accel_start <= 1'b0;
            done_flag   <= 1'b0;
            counter     <= '0;
        end else begin
            accel_start <= 1'b0;
            if (state == S_RUN && counter != 32'hFFFF_FFFF) begin
                counter <= counter + 32'd1;
            end

            // ASSERT_RST beats everything; accel_done beats a coincident STOP.
            if (ctrl_wr && cmd == CMD_ASSERT_RST) begin
                state       <= S_RST;
                accel_reset <= 1'b1;
            end else if (state == S_RUN && accel_done) begin
                state     <= S_DONE;
                done_flag <= 1'b1;
            end else if (ctrl_wr) begin
                case (cmd)
                    CMD_DEASSERT_RST: begin
                        if (state == S_RST) begin
                            state       <= S_IDLE;
                            accel_reset <= 1'b0;
                        end
                    end
                    CMD_START: begin
                        if (state == S_IDLE || state == S_STOP || state == S_DONE) begin
                            state       <= S_RUN;
                            accel_start <= 1'b1;
                            counter     <= '0;
                            done_flag   <= 1'b0;
                        end
                    end
                    CMD_STOP: begin
                        if (state == S_RUN) begin
                            state <= S_STOP;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read mux samples the current registers, so a same-cycle write is not visible.
    always_comb begin
        rd_mux = '0;
        if (bus.mmio_addr == STATUS0_DW) begin
            rd_mux = {59'b0, 1'b0, done_flag, state};
        end else if (bus.mmio_addr == STATUS8_DW) begin
            rd_mux = {32'b0, counter};
        end else if (bus.mmio_addr == DSM_DW) begin
            rd_mux = dsm_q;
        end else if (bus.mmio_addr == CTRL_DW) begin
            rd_mux = {61'b0, state};
        end else begin
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                if (bus.mmio_addr == BUF_DW + 16'(4 * i)) begin
                    rd_mux = addr_q[i];
                end
                if (bus.mmio_addr == BUF_DW + 16'(4 * i + 2)) begin
                    rd_mux = {32'b0, size_q[i]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_tid_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= bus.mmio_rd_valid;
            if (bus.mmio_rd_valid) begin
                rsp_tid_q  <= bus.mmio_tid;
                rsp_data_q <= rd_mux;
            end
        end
    end

    assign bus.mmio_rsp_valid = rsp_valid_q;
    assign bus.mmio_rsp_tid   = rsp_tid_q;
    assign bus.mmio_rsp_data  = rsp_data_q;
    assign dsm_base           = dsm_q;
    assign ctrl_state         = state;

    for (genvar g = 0; g < NUM_BUFFERS; g++) begin : g_pack
        assign buf_addr[64*g +: 64] = addr_q[g];
        assign buf_size[32*g +: 32] = size_q[g];
    end

endmodule

// File: tb/tb_hc_csr_bank.sv
// Directed self-checking bench for hc_csr_bank with NUM_BUFFERS=2 and default address map.
// Dword map: STATUS 0x40/0x42, DSM 0x44, CTRL 0x46, buf0 0x48/0x4A, buf1 0x4C/0x4E.
module tb_hc_csr_bank;

    localparam int NB = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            accel_done;
    logic [63:0]     dsm_base;
    logic [64*NB-1:0] buf_addr;
    logic [32*NB-1:0] buf_size;
    logic            accel_reset;
    logic            accel_start;
    logic [2:0]      ctrl_state;

    int vec = 0;
    int err = 0;

    hc_csr_bank_if bus ();

    hc_csr_bank #(.NUM_BUFFERS(NB)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .accel_done  (accel_done),
        .dsm_base    (dsm_base),
        .buf_addr    (buf_addr),
        .buf_size    (buf_size),
        .accel_reset (accel_reset),
        .accel_start (accel_start),
        .ctrl_state  (ctrl_state)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic mmio_write(input logic [15:0] a, input logic [63:0] d);
        bus.mmio_wr_valid = 1'b1;
        bus.mmio_addr     = a;
        bus.mmio_wdata    = d;
        @(posedge clk); #1;
        bus.mmio_wr_valid = 1'b0;
    endtask

    task automatic mmio_read(input logic [15:0] a, input logic [8:0] t);
        bus.mmio_rd_valid = 1'b1;
        bus.mmio_addr     = a;
        bus.mmio_tid      = t;
        @(posedge clk); #1;
        bus.mmio_rd_valid = 1'b0;
    endtask

    task automatic test_reset;
        vec++; if (ctrl_state !== 3'd0) begin err++; $display("FAIL rst_state got %0d want 0", ctrl_state); end
        vec++; if (accel_reset !== 1'b1) begin err++; $display("FAIL rst_accel_reset got %b want 1", accel_reset); end
        vec++; if (accel_start !== 1'b0) begin err++; $display("FAIL rst_accel_start got %b want 0", accel_start); end
        vec++; if (bus.mmio_rsp_valid !== 1'b0) begin err++; $display("FAIL rst_rsp_valid got %b want 0", bus.mmio_rsp_valid); end
        vec++; if (dsm_base !== 64'h0 || buf_addr !== '0 || buf_size !== '0) begin
            err++; $display("FAIL rst_regs dsm %h addr %h size %h want 0", dsm_base, buf_addr, buf_size); end
        mmio_read(16'h40, 9'h1A2);
        vec++; if (bus.mmio_rsp_valid !== 1'b1) begin err++; $display("FAIL rst_rd_valid got %b want 1", bus.mmio_rsp_valid); end
        vec++; if (bus.mmio_rsp_tid !== 9'h1A2) begin err++; $display("FAIL rst_rd_tid got %h want 1a2", bus.mmio_rsp_tid); end
        vec++; if (bus.mmio_rsp_data !== 64'h0) begin err++; $display("FAIL rst_rd_data got %h want 0", bus.mmio_rsp_data); end
        @(posedge clk); #1;
        vec++; if (bus.mmio_rsp_valid !== 1'b0) begin err++; $display("FAIL rsp_single got %b want 0", bus.mmio_rsp_valid); end
    endtask

    task automatic test_desc_write;
        mmio_write(16'h48, 64'h0000_0001_2345_6780);
        mmio_write(16'h4E, 64'hDEAD_BEEF_0000_1000);
        vec++; if (buf_addr[63:0] !== 64'h0000_0001_2345_6780) begin err++; $display("FAIL buf0_addr got %h want 0000000123456780", buf_addr[63:0]); end
        vec++; if (buf_size[63:32] !== 32'h1000) begin err++; $display("FAIL buf1_size got %h want 1000", buf_size[63:32]); end
        vec++; if (buf_size[31:0] !== 32'h0 || buf_addr[127:64] !== 64'h0) begin
            err++; $display("FAIL desc_others size0 %h addr1 %h want 0", buf_size[31:0], buf_addr[127:64]); end
        mmio_read(16'h48, 9'h011);
        vec++; if (bus.mmio_rsp_data !== 64'h0000_0001_2345_6780 || bus.mmio_rsp_tid !== 9'h011) begin
            err++; $display("FAIL rd_buf0_addr got %h tid %h want 0000000123456780 tid 011", bus.mmio_rsp_data, bus.mmio_rsp_tid); end
        mmio_read(16'h4E, 9'h012);
        vec++; if (bus.mmio_rsp_data !== 64'h1000) begin err++; $display("FAIL rd_buf1_size got %h want 1000", bus.mmio_rsp_data); end
    endtask

    task automatic test_dsm_rdwr;
        mmio_write(16'h44, 64'hAAAA_5555_0000_1111);
        vec++; if (dsm_base !== 64'hAAAA_5555_0000_1111) begin err++; $display("FAIL dsm_write got %h want aaaa555500001111", dsm_base); end
        // Same-cycle read and write of DSM: read sees the old value.
        bus.mmio_rd_valid = 1'b1; bus.mmio_wr_valid = 1'b1;
        bus.mmio_addr = 16'h44; bus.mmio_tid = 9'h055; bus.mmio_wdata = 64'h1234_5678_9ABC_DEF0;
        @(posedge clk); #1;
        bus.mmio_rd_valid = 1'b0; bus.mmio_wr_valid = 1'b0;
        vec++; if (bus.mmio_rsp_data !== 64'hAAAA_5555_0000_1111) begin err++; $display("FAIL rdwr_old got %h want aaaa555500001111", bus.mmio_rsp_data); end
        vec++; if (dsm_base !== 64'h1234_5678_9ABC_DEF0) begin err++; $display("FAIL rdwr_new got %h want 123456789abcdef0", dsm_base); end
        mmio_read(16'h7F, 9'h0F0);
        vec++; if (bus.mmio_rsp_valid !== 1'b1 || bus.mmio_rsp_data !== 64'h0) begin
            err++; $display("FAIL rd_unmapped valid %b data %h want 1 0", bus.mmio_rsp_valid, bus.mmio_rsp_data); end
    endtask

    task automatic test_ignored;
        mmio_write(16'h46, 64'd3);
        vec++; if (ctrl_state !== 3'd0 || accel_start !== 1'b0) begin
            err++; $display("FAIL start_in_rst state %0d start %b want 0 0", ctrl_state, accel_start); end
        mmio_write(16'h46, 64'd1);
        vec++; if (ctrl_state !== 3'd1 || accel_reset !== 1'b0) begin
            err++; $display("FAIL deassert state %0d reset %b want 1 0", ctrl_state, accel_reset); end
        mmio_write(16'h46, 64'd5);
        vec++; if (ctrl_state !== 3'd1 || accel_start !== 1'b0) begin
            err++; $display("FAIL cmd5 state %0d start %b want 1 0", ctrl_state, accel_start); end
        mmio_write(16'h50, 64'hFFFF_FFFF_FFFF_FFFF);
        vec++; if (buf_addr !== {64'h0, 64'h0000_0001_2345_6780}) begin err++; $display("FAIL buf2_ignored addr %h", buf_addr); end
        mmio_read(16'h50, 9'h050);
        vec++; if (bus.mmio_rsp_data !== 64'h0) begin err++; $display("FAIL rd_buf2 got %h want 0", bus.mmio_rsp_data); end
    endtask

    task automatic test_run;
        logic [31:0] cnt;
        mmio_write(16'h46, 64'd3);
        vec++; if (ctrl_state !== 3'd2 || accel_start !== 1'b1) begin
            err++; $display("FAIL start state %0d start %b want 2 1", ctrl_state, accel_start); end
        @(posedge clk); #1;
        vec++; if (accel_start !== 1'b0) begin err++; $display("FAIL start_pulse got %b want 0", accel_start); end
        repeat (98) @(posedge clk);
        #1;
        mmio_read(16'h42, 9'h042);
        cnt = bus.mmio_rsp_data[31:0];
        vec++; if (bus.mmio_rsp_data[63:32] !== 32'h0 || cnt < 32'd99 || cnt > 32'd101) begin
            err++; $display("FAIL run_count got %h want 100+-1", bus.mmio_rsp_data); end
        mmio_write(16'h48, 64'h5A5A_5A5A_5A5A_5A5A);
        vec++; if (buf_addr[63:0] !== 64'h0000_0001_2345_6780) begin err++; $display("FAIL freeze got %h want 0000000123456780", buf_addr[63:0]); end
        mmio_read(16'h46, 9'h046);
        vec++; if (bus.mmio_rsp_data !== 64'd2) begin err++; $display("FAIL rd_ctrl got %h want 2", bus.mmio_rsp_data); end
    endtask

    task automatic test_done_stop;
        accel_done = 1'b1;
        mmio_write(16'h46, 64'd7);
        accel_done = 1'b0;
        vec++; if (ctrl_state !== 3'd4) begin err++; $display("FAIL done_wins got %0d want 4", ctrl_state); end
        mmio_read(16'h40, 9'h0C0);
        vec++; if (bus.mmio_rsp_data !== 64'hC) begin err++; $display("FAIL status_done got %h want c", bus.mmio_rsp_data); end
    endtask

    task automatic test_back_to_back;
        bus.mmio_rd_valid = 1'b1; bus.mmio_addr = 16'h48; bus.mmio_tid = 9'h101;
        @(posedge clk); #1;
        bus.mmio_addr = 16'h4E; bus.mmio_tid = 9'h102;
        vec++; if (bus.mmio_rsp_valid !== 1'b1 || bus.mmio_rsp_tid !== 9'h101 || bus.mmio_rsp_data !== 64'h0000_0001_2345_6780) begin
            err++; $display("FAIL b2b_first v %b tid %h data %h", bus.mmio_rsp_valid, bus.mmio_rsp_tid, bus.mmio_rsp_data); end
        @(posedge clk); #1;
        bus.mmio_rd_valid = 1'b0;
        vec++; if (bus.mmio_rsp_valid !== 1'b1 || bus.mmio_rsp_tid !== 9'h102 || bus.mmio_rsp_data !== 64'h1000) begin
            err++; $display("FAIL b2b_second v %b tid %h data %h", bus.mmio_rsp_valid, bus.mmio_rsp_tid, bus.mmio_rsp_data); end
    endtask

    task automatic test_reset_midrun;
        mmio_write(16'h46, 64'd3);
        vec++; if (ctrl_state !== 3'd2) begin err++; $display("FAIL restart got %0d want 2", ctrl_state); end
        bus.mmio_rd_valid = 1'b1; bus.mmio_addr = 16'h44; bus.mmio_tid = 9'h1FF;
        reset = 1'b1;
        @(posedge clk); #1;
        bus.mmio_rd_valid = 1'b0;
        vec++; if (bus.mmio_rsp_valid !== 1'b0) begin err++; $display("FAIL mid_rsp_drop got %b want 0", bus.mmio_rsp_valid); end
        vec++; if (ctrl_state !== 3'd0 || accel_reset !== 1'b1 || accel_start !== 1'b0) begin
            err++; $display("FAIL mid_ctrl state %0d reset %b start %b want 0 1 0", ctrl_state, accel_reset, accel_start); end
        vec++; if (dsm_base !== 64'h0 || buf_addr !== '0 || buf_size !== '0) begin
            err++; $display("FAIL mid_regs dsm %h addr %h size %h want 0", dsm_base, buf_addr, buf_size); end
        reset = 1'b0;
        mmio_read(16'h42, 9'h003);
        vec++; if (bus.mmio_rsp_data !== 64'h0) begin err++; $display("FAIL mid_count got %h want 0", bus.mmio_rsp_data); end
    endtask

    initial begin
        reset = 1'b1;
        accel_done = 1'b0;
        bus.mmio_wr_valid = 1'b0;
        bus.mmio_rd_valid = 1'b0;
        bus.mmio_addr = '0;
        bus.mmio_tid = '0;
        bus.mmio_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_desc_write();
        test_dsm_rdwr();
        test_ignored();
        test_run();
        test_done_stop();
        test_back_to_back();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
